fetch_arbiter: RTL and testbench
================================

FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning the word-address width of the shared instruction memory.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, meaning the number of consecutive denied fetch cycles before fetch is forced to win.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports if_req  input  1 and if_addr  input  32, the fetch request and byte address from the IF stage.
REQ-006 SHALL have port if_flush  input  1  discard the fetch result returned in the next cycle (branch redirect).
REQ-007 SHALL have ports d_req  input  1, d_we  input  4 (byte write mask, 0 = read), d_addr  input  32 and d_wdata  input  32, the data-side request.
REQ-008 SHALL have port mem_rdata  input  32  synchronous-read memory output, valid one cycle after mem_en.
REQ-009 SHALL have ports mem_en  output  1, mem_we  output  4, mem_addr  output  ADDR_WIDTH and mem_wdata  output  32, the single memory port.
REQ-010 SHALL have ports if_stall  output  1 (fetch denied this cycle), if_inst  output  32 and if_inst_valid  output  1.
REQ-011 SHALL have ports d_stall  output  1 (data denied this cycle), d_rdata  output  32 and d_rvalid  output  1.

Function
REQ-012 SHALL grant at most one requester per cycle; the grant is combinational from the current requests and registered state.
REQ-013 SHALL give data priority when both request, unless starve_cnt equals STARVE_LIMIT, in which case fetch wins.
REQ-014 SHALL drive mem_addr from bits [ADDR_WIDTH+1:2] of the granted address and ignore bits [1:0].
REQ-015 SHALL drive mem_we = d_we and mem_wdata = d_wdata only on a data grant; otherwise mem_we = 0.
REQ-016 SHALL drive mem_en = 1 on any grant and 0 when neither requester is granted.
REQ-017 SHALL assert if_stall = if_req & ~fetch_grant and d_stall = d_req & ~data_grant in the same cycle.
REQ-018 SHALL keep a registered owner state: NONE, FETCH or DATA_RD, set from the current grant (data write -> NONE).
REQ-019 SHALL, when owner = FETCH and if_flush is low, drive if_inst = mem_rdata and if_inst_valid = 1.
REQ-020 SHALL, while owner is not FETCH, hold if_inst at the last captured instruction and drive if_inst_valid = 0.
REQ-021 SHALL capture mem_rdata into the hold register on every owner = FETCH cycle, so a stalled pipeline sees a stable instruction.
REQ-022 SHALL, when owner = FETCH and if_flush = 1, drive if_inst_valid = 0, leave the hold register unchanged and drive if_inst = 32'h0000_0013.
REQ-023 SHALL, when owner = DATA_RD, drive d_rdata = mem_rdata and d_rvalid = 1; otherwise d_rvalid = 0 and d_rdata = 0.
REQ-024 SHALL increment starve_cnt on each cycle with if_req & ~fetch_grant, saturating at STARVE_LIMIT.
REQ-025 SHALL clear starve_cnt on a fetch grant or when if_req is low.
REQ-026 SHALL give a fetch request with no data request a grant in the same cycle, with instruction data one cycle later (latency 1).

Reset
REQ-027 SHALL, on rst, set owner = NONE, starve_cnt = 0 and the hold register = 32'h0000_0013.
REQ-028 SHALL, on rst, set if_inst_valid = 0 and d_rvalid = 0 in the following cycle, including mid-transaction.
REQ-029 SHALL drop any memory result from a transaction in flight at reset.

Configuration
REQ-030 SHALL, with macro FETCH_ARB_STARVE_EN defined, implement starve_cnt and the forced fetch win in REQ-013 and REQ-024/025.
REQ-031 SHALL, without FETCH_ARB_STARVE_EN, use strict data priority with no counter logic, so fetch may starve indefinitely.

Verification
REQ-032 SHALL cover fetch only: if_req=1, if_addr=0x4000_0010 -> mem_addr=4, mem_en=1, if_stall=0; the next cycle gives if_inst=mem_rdata and if_inst_valid=1.
REQ-033 SHALL cover a collision: if_req=d_req=1, d_we=0, d_addr=0x20 -> mem_addr=8, if_stall=1, d_stall=0; the next cycle gives d_rvalid=1 and if_inst_valid=0.
REQ-034 SHALL cover starvation with FETCH_ARB_STARVE_EN and STARVE_LIMIT=3: d_req and if_req held high -> cycles 0-2 go to data and cycle 3 goes to fetch (d_stall=1); cycle 4 goes to data again.
REQ-035 SHALL cover a flush: fetch granted, then if_flush=1 in the next cycle -> if_inst_valid=0, if_inst=0x0000_0013, and the hold register keeps its prior value.
REQ-036 SHALL cover a write: d_we=4'b0011, d_wdata=0xDEAD_BEEF -> mem_we=4'b0011, and the next cycle gives d_rvalid=0 with owner NONE.
REQ-037 SHALL cover reset mid-read: rst asserted with owner = DATA_RD -> d_rvalid=0 and if_inst_valid=0 the next cycle, starve_cnt=0.

Source files
------------

// File: rtl/fetch_arbiter.sv
// rtl/fetch_arbiter.sv - shares one synchronous-read memory port between instruction fetch and data access.
// Optional macro FETCH_ARB_STARVE_EN adds an anti-starvation counter that forces a fetch win.
module fetch_arbiter #(
   parameter int ADDR_WIDTH   = 14,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   input  logic                  if_flush,
   input  logic                  d_req,
   input  logic [3:0]            d_we,
   input  logic [31:0]           d_addr,
   input  logic [31:0]           d_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  if_stall,
   output logic [31:0]           if_inst,
   output logic                  if_inst_valid,
   output logic                  d_stall,
   output logic [31:0]           d_rdata,
   output logic                  d_rvalid
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_DATA_RD
   } owner_t;

   owner_t      owner_q, owner_d;
   logic [31:0] hold_q, hold_d;
   logic        fetch_grant;
   logic        data_grant;

   // Word addressing: byte-offset and bits above the memory depth are not decoded.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                               d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

`ifdef FETCH_ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             starve_hit;

   assign starve_hit = (starve_cnt_q == LIMIT);

   always_comb begin
      data_grant  = d_req & ~(if_req & starve_hit);
      fetch_grant = if_req & ~data_grant;
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req || fetch_grant) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != LIMIT) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   always_comb begin
      data_grant  = d_req;
      fetch_grant = if_req & ~d_req;
   end
`endif

   always_comb begin
      mem_en    = fetch_grant | data_grant;
      mem_we    = 4'b0000;
      mem_wdata = 32'h0;
      mem_addr  = '0;
      if (data_grant) begin
         mem_we    = d_we;
         mem_wdata = d_wdata;
         mem_addr  = d_addr[ADDR_WIDTH+1:2];
      end else if (fetch_grant) begin
         mem_addr  = if_addr[ADDR_WIDTH+1:2];
      end
      if_stall = if_req & ~fetch_grant;
      d_stall  = d_req & ~data_grant;
   end

   // Writes return nothing, so they leave no owner for the next cycle.
   always_comb begin
      owner_d = OWN_NONE;
      if (data_grant) begin
         owner_d = (d_we == 4'b0000) ? OWN_DATA_RD : OWN_NONE;
      end else if (fetch_grant) begin
         owner_d = OWN_FETCH;
      end
   end

   always_comb begin
      hold_d        = hold_q;
      if_inst       = hold_q;
      if_inst_valid = 1'b0;
      d_rdata       = 32'h0;
      d_rvalid      = 1'b0;
      case (owner_q)
         OWN_FETCH: begin
            if (if_flush) begin
               if_inst = NOP_INST;
            end else begin
               if_inst       = mem_rdata;
               if_inst_valid = 1'b1;
               hold_d        = mem_rdata;
            end
         end
         OWN_DATA_RD: begin
            d_rdata  = mem_rdata;
            d_rvalid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         hold_q  <= NOP_INST;
      end else begin
         owner_q <= owner_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_fetch_arbiter.sv
// tb/tb_fetch_arbiter.sv - directed vector bench for fetch_arbiter.
module tb_fetch_arbiter;

`ifdef FETCH_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, d_req;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_we;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        if_stall, if_inst_valid, d_stall, d_rvalid;
   logic [31:0] if_inst, d_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_rdata(mem_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_stall(if_stall), .if_inst(if_inst), .if_inst_valid(if_inst_valid),
      .d_stall(d_stall), .d_rdata(d_rdata), .d_rvalid(d_rvalid)
   );

   typedef struct {
      logic        rst;
      logic        if_req;
      logic [31:0] if_addr;
      logic        if_flush;
      logic        d_req;
      logic [3:0]  d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [31:0] mem_rdata;
      logic        e_en;
      logic [3:0]  e_we;
      logic [13:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_if_stall;
      logic        e_d_stall;
      logic [31:0] e_inst;
      logic        e_iv;
      logic [31:0] e_drdata;
      logic        e_dv;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                        input logic dr, input logic [3:0] we, input logic [31:0] da,
                        input logic [31:0] dw, input logic [31:0] mr);
      rst = r; if_req = ir; if_addr = ia; if_flush = fl;
      d_req = dr; d_we = we; d_addr = da; d_wdata = dw; mem_rdata = mr;
   endtask

   initial begin
      vecs[0]  = '{1, 0, 32'h0,         0, 0, 4'h0, 32'h0,      32'h0,        32'h1111_1111,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'h0000_0013, 0, 32'h0,        0};
      vecs[1]  = '{0, 1, 32'h4000_0010, 0, 0, 4'h0, 32'h0,      32'h0,        32'h2222_2222,
                   1, 4'h0, 14'h4,    32'h0,        0, 0, 32'h0000_0013, 0, 32'h0,        0};
      vecs[2]  = '{0, 0, 32'h0,         0, 0, 4'h0, 32'h0,      32'h0,        32'hAAAA_0001,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'hAAAA_0001, 1, 32'h0,        0};
      vecs[3]  = '{0, 0, 32'h0,         0, 0, 4'h0, 32'h0,      32'h0,        32'h5555_5555,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'hAAAA_0001, 0, 32'h0,        0};
      vecs[4]  = '{0, 1, 32'h0000_0100, 0, 1, 4'h0, 32'h20,     32'h1234_5678, 32'h6666_6666,
                   1, 4'h0, 14'h8,    32'h1234_5678, 1, 0, 32'hAAAA_0001, 0, 32'h0,        0};
      vecs[5]  = '{0, 1, 32'h0000_0100, 0, 0, 4'h0, 32'h0,      32'h0,        32'hD00D_0001,
                   1, 4'h0, 14'h40,   32'h0,        0, 0, 32'hAAAA_0001, 0, 32'hD00D_0001, 1};
      vecs[6]  = '{0, 0, 32'h0,         1, 0, 4'h0, 32'h0,      32'h0,        32'hBBBB_0002,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'h0000_0013, 0, 32'h0,        0};
      vecs[7]  = '{0, 0, 32'h0,         0, 0, 4'h0, 32'h0,      32'h0,        32'h0,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'hAAAA_0001, 0, 32'h0,        0};
      vecs[8]  = '{0, 0, 32'h0,         0, 1, 4'h3, 32'hFFFF,   32'hDEAD_BEEF, 32'h4444_4444,
                   1, 4'h3, 14'h3FFF, 32'hDEAD_BEEF, 0, 0, 32'hAAAA_0001, 0, 32'h0,        0};
      vecs[9]  = '{0, 0, 32'h0,         0, 0, 4'h0, 32'h0,      32'h0,        32'h7777_7777,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'hAAAA_0001, 0, 32'h0,        0};
      vecs[10] = '{0, 1, 32'h1234_5678, 0, 0, 4'h0, 32'h0,      32'h0,        32'h8888_8888,
                   1, 4'h0, 14'h159E, 32'h0,        0, 0, 32'hAAAA_0001, 0, 32'h0,        0};
      vecs[11] = '{0, 1, 32'h1234_567C, 0, 0, 4'h0, 32'h0,      32'h0,        32'hCAFE_0003,
                   1, 4'h0, 14'h159F, 32'h0,        0, 0, 32'hCAFE_0003, 1, 32'h0,        0};
      vecs[12] = '{0, 0, 32'h0,         0, 1, 4'h0, 32'h8,      32'h0,        32'hCAFE_0004,
                   1, 4'h0, 14'h2,    32'h0,        0, 0, 32'hCAFE_0004, 1, 32'h0,        0};
      vecs[13] = '{1, 0, 32'h0,         0, 0, 4'h0, 32'h0,      32'h0,        32'h0BAD_0001,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'hCAFE_0004, 0, 32'h0BAD_0001, 1};
      vecs[14] = '{0, 0, 32'h0,         0, 0, 4'h0, 32'h0,      32'h0,        32'h9999_9999,
                   0, 4'h0, 14'h0,    32'h0,        0, 0, 32'h0000_0013, 0, 32'h0,        0};

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr, vecs[i].if_flush, vecs[i].d_req,
               vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata, vecs[i].mem_rdata);
         @(negedge clk);
         chk($sformatf("r%0d_mem_en", i),    {31'b0, mem_en},        {31'b0, vecs[i].e_en});
         chk($sformatf("r%0d_mem_we", i),    {28'b0, mem_we},        {28'b0, vecs[i].e_we});
         chk($sformatf("r%0d_mem_addr", i),  {18'b0, mem_addr},      {18'b0, vecs[i].e_addr});
         chk($sformatf("r%0d_mem_wdata", i), mem_wdata,              vecs[i].e_wdata);
         chk($sformatf("r%0d_if_stall", i),  {31'b0, if_stall},      {31'b0, vecs[i].e_if_stall});
         chk($sformatf("r%0d_d_stall", i),   {31'b0, d_stall},       {31'b0, vecs[i].e_d_stall});
         chk($sformatf("r%0d_if_inst", i),   if_inst,                vecs[i].e_inst);
         chk($sformatf("r%0d_if_valid", i),  {31'b0, if_inst_valid}, {31'b0, vecs[i].e_iv});
         chk($sformatf("r%0d_d_rdata", i),   d_rdata,                vecs[i].e_drdata);
         chk($sformatf("r%0d_d_rvalid", i),  {31'b0, d_rvalid},      {31'b0, vecs[i].e_dv});
         @(posedge clk);
         #1;
      end

      // Build up starvation, then reset: the counter must restart from zero.
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 32'h80, 0, 1, 4'h0, 32'h40, 32'h0, 32'h0);
         @(negedge clk);
         chk($sformatf("pre%0d_d_stall", k), {31'b0, d_stall}, 32'h0);
         @(posedge clk);
         #1;
      end
      drive(1, 1, 32'h80, 0, 1, 4'h0, 32'h40, 32'h0, 32'h0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 6; k++) begin
         logic exp_fetch;
         logic prev_fetch;
         exp_fetch  = STARVE && (k == 3);
         prev_fetch = STARVE && (k == 4);
         drive(0, 1, 32'h80, 0, 1, 4'h0, 32'h40, 32'h0, 32'hF000_0000 + k);
         @(negedge clk);
         chk($sformatf("st%0d_if_stall", k), {31'b0, if_stall}, {31'b0, ~exp_fetch});
         chk($sformatf("st%0d_d_stall", k),  {31'b0, d_stall},  {31'b0, exp_fetch});
         chk($sformatf("st%0d_mem_addr", k), {18'b0, mem_addr}, exp_fetch ? 32'h20 : 32'h10);
         if (k == 0) begin
            chk("st0_d_rvalid_after_rst",  {31'b0, d_rvalid},      32'h0);
            chk("st0_if_valid_after_rst",  {31'b0, if_inst_valid}, 32'h0);
         end else begin
            chk($sformatf("st%0d_if_valid", k), {31'b0, if_inst_valid}, {31'b0, prev_fetch});
            chk($sformatf("st%0d_d_rvalid", k), {31'b0, d_rvalid},      {31'b0, ~prev_fetch});
            if (prev_fetch) chk($sformatf("st%0d_if_inst", k), if_inst, 32'hF000_0004);
         end
         @(posedge clk);
         #1;
      end

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
